// File: rtl/spi_debug_pkg.sv
// Shared definitions for the SPI debug-byte transmitter and its FIFO.
package spi_debug_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/debug_byte_fifo.sv
// Single-clock show-ahead FIFO; a pop on empty is ignored, a push on full is
// accepted only when a pop frees a slot in the same cycle.
module debug_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_debug_tx.sv
// SPI mode-0 peripheral that queues captured debug bytes and shifts them out
// MSB-first; SCLK/CSn are oversampled on i_clk.
module spi_debug_tx #(
  parameter int                    DATA_WIDTH  = spi_debug_pkg::DATA_WIDTH_DEF,
  parameter int                    FIFO_DEPTH  = 16,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = spi_debug_pkg::IDLE_BYTE_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_capture,
  input  logic                         i_clear_overflow,
  input  logic                         i_spi_sclk,
  input  logic                         i_spi_csn,
  output logic                         o_spi_miso,
  output logic                         o_miso_oe,
  output logic                         o_datasent,
  output logic                         o_abort,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FIFO_DEPTH):0]  o_level,
  output logic                         o_overflow
);
  import spi_debug_pkg::*;

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic                   cap_d;
  logic                   push;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic                   sclk_d;
  logic                   csn_d;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   csn_rise;
  logic                   csn_fall;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   frame_done;
  logic                   reload;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  head;
  logic [DATA_WIDTH-1:0]  load_byte;

  assign push      = i_capture & ~cap_d;
  assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
  assign csn_rise  =  csn_sync[SYNC_STAGES-1]  & ~csn_d;
  assign csn_fall  = ~csn_sync[SYNC_STAGES-1]  &  csn_d;

  // A CSn rise in the same cycle as the last falling SCLK wins, so no byte is lost to a reload.
  assign reload    = (state == SHIFT) & ~csn_rise & sclk_fall & frame_done;
  assign pop       = (state == LOAD) | reload;
  assign load_byte = o_empty ? IDLE_BYTE : head;

  debug_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (push),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .full  (o_full),
    .empty (o_empty),
    .level (o_level)
  );

  // Input conditioning: capture edge detect, pin synchronisers, overflow flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cap_d      <= 1'b0;
      sclk_sync  <= '0;
      csn_sync   <= '1;
      sclk_d     <= 1'b0;
      csn_d      <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      cap_d     <= i_capture;
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_spi_csn};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
      if (push && o_full && !pop) o_overflow <= 1'b1;
      else if (i_clear_overflow)  o_overflow <= 1'b0;
    end
  end

  // Frame sequencer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      o_spi_miso <= 1'b0;
      o_miso_oe  <= 1'b0;
      o_datasent <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      o_datasent <= 1'b0;
      o_abort    <= 1'b0;
      case (state)
        IDLE: begin
          o_spi_miso <= 1'b0;
          o_miso_oe  <= 1'b0;
          if (csn_fall) state <= LOAD;
        end
        LOAD: begin
          shreg      <= load_byte;
          bit_cnt    <= '0;
          frame_done <= 1'b0;
          o_spi_miso <= load_byte[DATA_WIDTH-1];
          o_miso_oe  <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (csn_rise) begin
            state      <= IDLE;
            o_spi_miso <= 1'b0;
            o_miso_oe  <= 1'b0;
            if (bit_cnt != '0 && !frame_done) o_abort <= 1'b1;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
              o_datasent <= 1'b1;
              frame_done <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (frame_done) begin
              shreg      <= load_byte;
              o_spi_miso <= load_byte[DATA_WIDTH-1];
              bit_cnt    <= '0;
              frame_done <= 1'b0;
            end else begin
              shreg      <= shreg << 1;
              o_spi_miso <= shreg[DATA_WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
